// File: rtl/cpu_pkg.sv
// Shared definitions for the tiny CPU core: datapath widths, reset vector,
// opcode encodings and the jump-target field of an instruction word.
package cpu_pkg;

    localparam int CPU_AWIDTH = 16;
    localparam int CPU_DWIDTH = 16;
    localparam logic [CPU_AWIDTH-1:0] CPU_RESET_PC = '0;

    typedef enum logic [3:0] {
        OP_MOV = 4'b0000,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0101,
        OP_OR  = 4'b1001,
        OP_JMP = 4'b1010
    } opcode_e;

    localparam int JMP_TGT_MSB = 7;
    localparam int JMP_TGT_LSB = 0;

    // Jump immediates are 8 bits and zero-extended to a full address.
    function automatic logic [CPU_AWIDTH-1:0] jump_target(input logic [CPU_DWIDTH-1:0] instr);
        return {{(CPU_AWIDTH - (JMP_TGT_MSB - JMP_TGT_LSB + 1)){1'b0}}, instr[JMP_TGT_MSB:JMP_TGT_LSB]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch queue of {instr, pc} entries with simultaneous
// push/pop and a synchronous flush; the head reads as zero when empty.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the zero-when-empty output mux hides stale contents.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the pc, requests ROM words into the
// prefetch queue and flushes/restarts on jump redirects from execute.
module ifetch_ctrl
    import cpu_pkg::*;
#(
    parameter int              AWIDTH   = CPU_AWIDTH,
    parameter int              DWIDTH   = CPU_DWIDTH,
    parameter int              DEPTH    = 2,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(CPU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [AWIDTH-1:0] rom_addr,
    output logic              rom_ready,
    input  logic [DWIDTH-1:0] rom_data,
    input  logic              rom_valid,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DWIDTH-1:0] instr_data,
    output logic [AWIDTH-1:0] instr_pc,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] redirect_addr,
    output logic              empty
);

    logic [AWIDTH-1:0]        r_pc;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [DWIDTH+AWIDTH-1:0] w_head;

    // Redirect masks both handshakes so the flush never races a push or pop.
    assign instr_valid = ~w_empty & ~redirect;
    assign w_pop       = instr_valid & instr_ready;
    assign rom_ready   = rst & run & ~redirect & (~w_full | w_pop);
    assign w_push      = rom_ready & rom_valid;

    assign rom_addr    = r_pc;
    assign empty       = w_empty;
    assign instr_data  = w_head[DWIDTH+AWIDTH-1:AWIDTH];
    assign instr_pc    = w_head[AWIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_addr;
        end else if (w_push) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (DWIDTH + AWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({rom_data, r_pc}),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: fill, backpressure, redirect, run gating,
// ROM stall, pc wrap and asynchronous reset, against a constant ROM image.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b1;
    logic        rom_valid = 1'b1;
    logic        instr_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;

    logic [15:0] rom_addr, rom_data, instr_data, instr_pc;
    logic        rom_ready, instr_valid, empty;

    logic [15:0] w2_rom_addr, w2_rom_data, w2_instr_data, w2_instr_pc;
    logic        w2_rom_ready, w2_instr_valid, w2_empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        case (a)
            8'd0:    return 16'h0008;
            8'd1:    return 16'h0402;
            8'd2:    return 16'h2401;
            8'd7:    return 16'h5100;
            8'd8:    return 16'h08FF;
            default: return {8'hA5, a};
        endcase
    endfunction

    assign rom_data    = rom_word(rom_addr[7:0]);
    assign w2_rom_data = rom_word(w2_rom_addr[7:0]);

    ifetch_ctrl #(.AWIDTH(16), .DWIDTH(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .run(run),
        .rom_addr(rom_addr), .rom_ready(rom_ready), .rom_data(rom_data), .rom_valid(rom_valid),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_addr(redirect_addr), .empty(empty)
    );

    ifetch_ctrl #(.AWIDTH(16), .DWIDTH(16), .DEPTH(2), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst), .run(run),
        .rom_addr(w2_rom_addr), .rom_ready(w2_rom_ready), .rom_data(w2_rom_data), .rom_valid(rom_valid),
        .instr_valid(w2_instr_valid), .instr_ready(instr_ready), .instr_data(w2_instr_data), .instr_pc(w2_instr_pc),
        .redirect(redirect), .redirect_addr(redirect_addr), .empty(w2_empty)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Holds reset for two cycles, then releases it mid-cycle: the next edge is the first fetch.
    task automatic apply_reset(input logic ready);
        rst = 1'b0; run = 1'b1; rom_valid = 1'b1; instr_ready = ready;
        redirect = 1'b0; redirect_addr = '0;
        tick(); tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; rom_valid = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({rom_ready, instr_valid, instr_data, instr_pc, rom_addr, empty} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1}) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got rdy=%b vld=%b data=%h pc=%h addr=%h empty=%b, want 0 0 0000 0000 0000 1",
                         c, rom_ready, instr_valid, instr_data, instr_pc, rom_addr, empty);
            end
        end
        checks++;
        if ({w2_rom_ready, w2_instr_valid, w2_instr_data, w2_instr_pc, w2_rom_addr} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'hFFFF}) begin
            errors++;
            $display("FAIL reset_wrap_dut: got rdy=%b vld=%b data=%h pc=%h addr=%h, want 0 0 0000 0000 ffff",
                     w2_rom_ready, w2_instr_valid, w2_instr_data, w2_instr_pc, w2_rom_addr);
        end
        rst = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        checks++;
        if ({rom_ready, instr_valid, rom_addr} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL fill_first_req: got rdy=%b vld=%b addr=%h, want 1 0 0000", rom_ready, instr_valid, rom_addr);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] pk;
            pk = k[15:0];
            checks++;
            if ({instr_valid, instr_data, instr_pc} !== {1'b1, rom_word(pk[7:0]), pk}) begin
                errors++;
                $display("FAIL fill_seq%0d: got vld=%b data=%h pc=%h, want 1 %h %h",
                         k, instr_valid, instr_data, instr_pc, rom_word(pk[7:0]), pk);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int pushes;
        pushes = 0;
        apply_reset(1'b0);
        for (int c = 0; c < 5; c++) begin
            if (rom_ready && rom_valid) pushes++;
            if (c < 4) tick();
        end
        checks++;
        if (pushes != 2) begin
            errors++;
            $display("FAIL bp_push_count: got %0d, want 2", pushes);
        end
        checks++;
        if ({rom_ready, rom_addr, instr_valid, instr_data, instr_pc} !== {1'b0, 16'h0002, 1'b1, 16'h0008, 16'h0000}) begin
            errors++;
            $display("FAIL bp_hold: got rdy=%b addr=%h vld=%b data=%h pc=%h, want 0 0002 1 0008 0000",
                     rom_ready, rom_addr, instr_valid, instr_data, instr_pc);
        end
        instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            logic [15:0] pk;
            pk = k[15:0];
            checks++;
            if ({instr_valid, instr_pc, instr_data, rom_ready, rom_addr} !==
                {1'b1, pk, rom_word(pk[7:0]), 1'b1, pk + 16'd2}) begin
                errors++;
                $display("FAIL bp_drain%0d: got vld=%b pc=%h data=%h rdy=%b addr=%h, want 1 %h %h 1 %h",
                         k, instr_valid, instr_pc, instr_data, rom_ready, rom_addr, pk, rom_word(pk[7:0]), pk + 16'd2);
            end
            tick();
        end
    endtask

    // Queue stays full while popping and refilling: removing the pop must block the request.
    task automatic test_full_pop_push();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] pk;
            pk = 16'(6 + k);
            instr_ready = 1'b0;
            #1;
            checks++;
            if ({rom_ready, instr_pc} !== {1'b0, pk}) begin
                errors++;
                $display("FAIL full_no_pop%0d: got rdy=%b pc=%h, want 0 %h", k, rom_ready, instr_pc, pk);
            end
            instr_ready = 1'b1;
            #1;
            checks++;
            if ({rom_ready, rom_addr} !== {1'b1, pk + 16'd2}) begin
                errors++;
                $display("FAIL full_pop_push%0d: got rdy=%b addr=%h, want 1 %h", k, rom_ready, rom_addr, pk + 16'd2);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        tick(); tick();
        instr_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if ({rom_addr, instr_pc, rom_ready} !== {16'h0007, 16'h0005, 1'b1}) begin
            errors++;
            $display("FAIL redir_setup: got addr=%h pc=%h rdy=%b, want 0007 0005 1", rom_addr, instr_pc, rom_ready);
        end
        redirect = 1'b1;
        redirect_addr = 16'h0008;
        #1;
        checks++;
        if ({instr_valid, rom_ready} !== 2'b00) begin
            errors++;
            $display("FAIL redir_cycle: got vld=%b rdy=%b, want 0 0", instr_valid, rom_ready);
        end
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if ({rom_addr, empty, instr_valid, rom_ready} !== {16'h0008, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL redir_restart: got addr=%h empty=%b vld=%b rdy=%b, want 0008 1 0 1",
                     rom_addr, empty, instr_valid, rom_ready);
        end
        tick();
        checks++;
        if ({instr_valid, instr_data, instr_pc} !== {1'b1, 16'h08FF, 16'h0008}) begin
            errors++;
            $display("FAIL redir_target: got vld=%b data=%h pc=%h, want 1 08ff 0008", instr_valid, instr_data, instr_pc);
        end
        tick();
        checks++;
        if ({instr_valid, instr_data, instr_pc} !== {1'b1, rom_word(8'd9), 16'h0009}) begin
            errors++;
            $display("FAIL redir_next: got vld=%b data=%h pc=%h, want 1 %h 0009", instr_valid, instr_data, instr_pc, rom_word(8'd9));
        end
    endtask

    task automatic test_run_gating();
        apply_reset(1'b0);
        tick(); tick();
        run = 1'b0;
        instr_ready = 1'b1;
        #1;
        checks++;
        if ({rom_ready, instr_valid, instr_pc} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL run_off_full: got rdy=%b vld=%b pc=%h, want 0 1 0000", rom_ready, instr_valid, instr_pc);
        end
        tick();
        checks++;
        if ({rom_ready, instr_valid, instr_data, instr_pc} !== {1'b0, 1'b1, 16'h0402, 16'h0001}) begin
            errors++;
            $display("FAIL run_off_drain: got rdy=%b vld=%b data=%h pc=%h, want 0 1 0402 0001",
                     rom_ready, instr_valid, instr_data, instr_pc);
        end
        tick();
        checks++;
        if ({rom_ready, instr_valid, empty, rom_addr, instr_data} !== {1'b0, 1'b0, 1'b1, 16'h0002, 16'h0000}) begin
            errors++;
            $display("FAIL run_off_empty: got rdy=%b vld=%b empty=%b addr=%h data=%h, want 0 0 1 0002 0000",
                     rom_ready, instr_valid, empty, rom_addr, instr_data);
        end
    endtask

    task automatic test_rom_stall();
        run = 1'b1;
        rom_valid = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({rom_ready, rom_addr, empty} !== {1'b1, 16'h0002, 1'b1}) begin
                errors++;
                $display("FAIL stall%0d: got rdy=%b addr=%h empty=%b, want 1 0002 1", c, rom_ready, rom_addr, empty);
            end
            tick();
        end
        rom_valid = 1'b1;
        tick();
        checks++;
        if ({instr_valid, instr_data, instr_pc, rom_addr} !== {1'b1, 16'h2401, 16'h0002, 16'h0003}) begin
            errors++;
            $display("FAIL stall_resume: got vld=%b data=%h pc=%h addr=%h, want 1 2401 0002 0003",
                     instr_valid, instr_data, instr_pc, rom_addr);
        end
    endtask

    task automatic test_wrap();
        apply_reset(1'b1);
        checks++;
        if ({w2_rom_ready, w2_rom_addr} !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL wrap_start: got rdy=%b addr=%h, want 1 ffff", w2_rom_ready, w2_rom_addr);
        end
        tick();
        checks++;
        if ({w2_instr_valid, w2_instr_pc, w2_instr_data} !== {1'b1, 16'hFFFF, 16'hA5FF}) begin
            errors++;
            $display("FAIL wrap_top: got vld=%b pc=%h data=%h, want 1 ffff a5ff", w2_instr_valid, w2_instr_pc, w2_instr_data);
        end
        tick();
        checks++;
        if ({w2_instr_valid, w2_instr_pc, w2_instr_data, w2_rom_addr} !== {1'b1, 16'h0000, 16'h0008, 16'h0001}) begin
            errors++;
            $display("FAIL wrap_zero: got vld=%b pc=%h data=%h addr=%h, want 1 0000 0008 0001",
                     w2_instr_valid, w2_instr_pc, w2_instr_data, w2_rom_addr);
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b1);
        tick(); tick();
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({rom_ready, instr_valid, instr_data, instr_pc, rom_addr, empty} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b vld=%b data=%h pc=%h addr=%h empty=%b, want 0 0 0000 0000 0000 1",
                     rom_ready, instr_valid, instr_data, instr_pc, rom_addr, empty);
        end
        checks++;
        if ({w2_instr_valid, w2_instr_pc, w2_rom_addr} !== {1'b0, 16'h0000, 16'hFFFF}) begin
            errors++;
            $display("FAIL async_reset_wrap: got vld=%b pc=%h addr=%h, want 0 0000 ffff", w2_instr_valid, w2_instr_pc, w2_rom_addr);
        end
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_full_pop_push();
        test_redirect();
        test_run_gating();
        test_rom_stall();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
